// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: the initiator state encoding, default bus
// widths and the timeout counter sizing rule. Peripherals import this too.
package wb_pkg;

  localparam int WB_DATA_WIDTH     = 8;
  localparam int WB_ADDR_WIDTH     = 17;
  localparam int WB_TIMEOUT_CYCLES = 255;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQUEST  = 2'd1,
    WAIT_ACK = 2'd2
  } wb_state_e;

  // Bits needed to hold 0..timeout; never narrower than one bit.
  function automatic int counter_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/wb_timeout_counter.sv
// Counts the cycles a bus cycle has been open and flags the last permitted
// cycle. With TIMEOUT_CYCLES = 0 the flag never rises.
module wb_timeout_counter
  import wb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = WB_TIMEOUT_CYCLES
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CW = counter_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

  logic [CW-1:0] r_count;

  // Cycle counter: cleared on acceptance, advances while the bus cycle is open.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of block ordering in the simulator.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_expired = (TIMEOUT_CYCLES != 0) && (r_count == LAST);

endmodule

// File: rtl/wb_initiator.sv
// Wishbone B4 pipelined initiator: one client request becomes one bus cycle,
// answered by a single-cycle response pulse carrying read data or a timeout.
module wb_initiator
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH     = WB_DATA_WIDTH,
  parameter int ADDR_WIDTH     = WB_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES = WB_TIMEOUT_CYCLES
) (
  input  logic                  wb_clock_i,
  input  logic                  wb_reset_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_data_i,
  output logic                  resp_valid_o,
  output logic [DATA_WIDTH-1:0] resp_data_o,
  output logic                  resp_err_o,
  output logic [ADDR_WIDTH-1:0] wb_addr_o,
  output logic [DATA_WIDTH-1:0] wb_data_o,
  input  logic [DATA_WIDTH-1:0] wb_data_i,
  output logic                  wb_we_o,
  output logic                  wb_cycle_o,
  output logic                  wb_strobe_o,
  input  logic                  wb_stall_i,
  input  logic                  wb_ack_i
);

  wb_state_e             r_state;
  logic                  r_cyc;
  logic                  r_stb;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_resp_valid;
  logic                  r_resp_err;
  logic [DATA_WIDTH-1:0] r_resp_data;

  logic w_accept;
  logic w_ack_ok;
  logic w_expired;
  logic w_timeout;

  // An ack only counts once the strobe has been taken (no stall) or afterwards.
  assign w_accept  = (r_state == IDLE) && req_valid_i;
  assign w_ack_ok  = wb_ack_i && (((r_state == REQUEST) && !wb_stall_i) || (r_state == WAIT_ACK));
  assign w_timeout = w_expired && r_cyc && !w_ack_ok;

  wb_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk     (wb_clock_i),
    .i_rst     (wb_reset_i),
    .i_clear   (w_accept),
    .i_enable  (r_cyc),
    .o_expired (w_expired)
  );

  // Bus FSM with registered bus and response outputs; ack beats timeout.
  always_ff @(posedge wb_clock_i or posedge wb_reset_i) begin
    if (wb_reset_i) begin
      r_state      <= IDLE;
      r_cyc        <= 1'b0;
      r_stb        <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_data  <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      if (w_ack_ok) begin
        r_cyc        <= 1'b0;
        r_stb        <= 1'b0;
        r_resp_valid <= 1'b1;
        r_resp_err   <= 1'b0;
        if (!r_we) begin
          r_resp_data <= wb_data_i;
        end
        r_state      <= IDLE;
      end else if (w_timeout) begin
        r_cyc        <= 1'b0;
        r_stb        <= 1'b0;
        r_resp_valid <= 1'b1;
        r_resp_err   <= 1'b1;
        r_resp_data  <= '0;
        r_state      <= IDLE;
      end else begin
        case (r_state)
          IDLE: begin
            if (req_valid_i) begin
              r_addr  <= req_addr_i;
              r_wdata <= req_data_i;
              r_we    <= req_we_i;
              r_cyc   <= 1'b1;
              r_stb   <= 1'b1;
              r_state <= REQUEST;
            end
          end
          REQUEST: begin
            if (!wb_stall_i) begin
              r_stb   <= 1'b0;
              r_state <= WAIT_ACK;
            end
          end
          WAIT_ACK: begin
            r_state <= WAIT_ACK;
          end
          default: begin
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign req_ready_o  = (r_state == IDLE);
  assign resp_valid_o = r_resp_valid;
  assign resp_data_o  = r_resp_data;
  assign resp_err_o   = r_resp_err;
  assign wb_addr_o    = r_addr;
  assign wb_data_o    = r_wdata;
  assign wb_we_o      = r_we;
  assign wb_cycle_o   = r_cyc;
  assign wb_strobe_o  = r_stb;

endmodule

// File: tb/tb_wb_initiator.sv
// Directed bench for wb_initiator: instance a has an 8-cycle timeout,
// instance b has the timeout disabled. Inputs change and outputs are
// sampled on the falling clock edge.
module tb_wb_initiator;
  import wb_pkg::*;

  localparam int DW = 8;
  localparam int AW = 17;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  logic          a_req_valid, a_req_ready, a_req_we;
  logic [AW-1:0] a_req_addr;
  logic [DW-1:0] a_req_data;
  logic          a_resp_valid, a_resp_err;
  logic [DW-1:0] a_resp_data;
  logic [AW-1:0] a_wb_addr;
  logic [DW-1:0] a_wb_wdata, a_wb_rdata;
  logic          a_wb_we, a_wb_cyc, a_wb_stb, a_wb_stall, a_wb_ack;

  logic          b_req_valid, b_req_ready, b_req_we;
  logic [AW-1:0] b_req_addr;
  logic [DW-1:0] b_req_data;
  logic          b_resp_valid, b_resp_err;
  logic [DW-1:0] b_resp_data;
  logic [AW-1:0] b_wb_addr;
  logic [DW-1:0] b_wb_wdata, b_wb_rdata;
  logic          b_wb_we, b_wb_cyc, b_wb_stb, b_wb_stall, b_wb_ack;

  wb_initiator #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(8)) u_dut_a (
    .wb_clock_i (clk),          .wb_reset_i  (rst),
    .req_valid_i(a_req_valid),  .req_ready_o (a_req_ready),
    .req_we_i   (a_req_we),     .req_addr_i  (a_req_addr),
    .req_data_i (a_req_data),   .resp_valid_o(a_resp_valid),
    .resp_data_o(a_resp_data),  .resp_err_o  (a_resp_err),
    .wb_addr_o  (a_wb_addr),    .wb_data_o   (a_wb_wdata),
    .wb_data_i  (a_wb_rdata),   .wb_we_o     (a_wb_we),
    .wb_cycle_o (a_wb_cyc),     .wb_strobe_o (a_wb_stb),
    .wb_stall_i (a_wb_stall),   .wb_ack_i    (a_wb_ack)
  );

  wb_initiator #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(0)) u_dut_b (
    .wb_clock_i (clk),          .wb_reset_i  (rst),
    .req_valid_i(b_req_valid),  .req_ready_o (b_req_ready),
    .req_we_i   (b_req_we),     .req_addr_i  (b_req_addr),
    .req_data_i (b_req_data),   .resp_valid_o(b_resp_valid),
    .resp_data_o(b_resp_data),  .resp_err_o  (b_resp_err),
    .wb_addr_o  (b_wb_addr),    .wb_data_o   (b_wb_wdata),
    .wb_data_i  (b_wb_rdata),   .wb_we_o     (b_wb_we),
    .wb_cycle_o (b_wb_cyc),     .wb_strobe_o (b_wb_stb),
    .wb_stall_i (b_wb_stall),   .wb_ack_i    (b_wb_ack)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and land on the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  int stb_cnt;
  int cyc_cnt;
  int got;

  initial begin
    a_req_valid = 0; a_req_we = 0; a_req_addr = '0; a_req_data = '0;
    a_wb_rdata  = '0; a_wb_stall = 0; a_wb_ack = 0;
    b_req_valid = 0; b_req_we = 0; b_req_addr = '0; b_req_data = '0;
    b_wb_rdata  = '0; b_wb_stall = 0; b_wb_ack = 0;

    // Reset state, reached before any clock edge.
    #1 rst = 1'b1;
    #1;
    check("rst_cyc",   a_wb_cyc, 0);
    check("rst_stb",   a_wb_stb, 0);
    check("rst_we",    a_wb_we, 0);
    check("rst_rv",    a_resp_valid, 0);
    check("rst_err",   a_resp_err, 0);
    check("rst_addr",  a_wb_addr, 0);
    check("rst_wdata", a_wb_wdata, 0);
    check("rst_rdata", a_resp_data, 0);
    check("rst_ready", a_req_ready, 1);
    check("rst_b_cyc", b_wb_cyc, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // 1. Write then read back through an SRAM-like peripheral.
    a_req_valid = 1; a_req_we = 1; a_req_addr = 17'h12345; a_req_data = 8'hA5;
    step();
    check("t1_cyc",   a_wb_cyc, 1);
    check("t1_stb",   a_wb_stb, 1);
    check("t1_addr",  a_wb_addr, 17'h12345);
    check("t1_wdata", a_wb_wdata, 8'hA5);
    check("t1_we",    a_wb_we, 1);
    check("t1_ready", a_req_ready, 0);
    a_req_valid = 0;
    step();
    check("t1_stb_dn", a_wb_stb, 0);
    check("t1_cyc_up", a_wb_cyc, 1);
    a_wb_ack = 1;
    step();
    check("t1_rv",    a_resp_valid, 1);
    check("t1_err",   a_resp_err, 0);
    check("t1_cycdn", a_wb_cyc, 0);
    check("t1_rdy",   a_req_ready, 1);
    a_wb_ack = 0;
    a_req_valid = 1; a_req_we = 0;
    step();
    check("t1r_stb", a_wb_stb, 1);
    check("t1r_rv",  a_resp_valid, 0);
    a_req_valid = 0; a_wb_stall = 1;
    step();
    check("t1r_stall_stb", a_wb_stb, 1);
    a_wb_stall = 0;
    step();
    check("t1r_stb_dn", a_wb_stb, 0);
    a_wb_ack = 1; a_wb_rdata = 8'hA5;
    step();
    check("t1r_rv",   a_resp_valid, 1);
    check("t1r_data", a_resp_data, 8'hA5);
    a_wb_ack = 0; a_wb_rdata = 8'h00;
    step();
    check("t1r_rv_dn", a_resp_valid, 0);

    // 2. Read with a 3-cycle stall; acks during the stall must be ignored.
    a_req_valid = 1; a_req_we = 0; a_req_addr = 17'h0ABCD;
    step();
    stb_cnt = 0;
    if (a_wb_stb) stb_cnt++;
    a_req_valid = 0; a_req_addr = 17'h00000; a_wb_stall = 1; a_wb_ack = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (a_wb_stb) stb_cnt++;
      check("t2_addr_stable", a_wb_addr, 17'h0ABCD);
      check("t2_no_resp",     a_resp_valid, 0);
    end
    a_wb_stall = 0; a_wb_ack = 0;
    step();
    if (a_wb_stb) stb_cnt++;
    check("t2_stb_cycles", stb_cnt, 4);
    step();
    check("t2_wait_cyc", a_wb_cyc, 1);
    check("t2_wait_rv",  a_resp_valid, 0);
    a_wb_ack = 1; a_wb_rdata = 8'h3C;
    step();
    check("t2_rv",   a_resp_valid, 1);
    check("t2_data", a_resp_data, 8'h3C);
    check("t2_err",  a_resp_err, 0);
    a_wb_ack = 0;

    // 3. Timeout after 8 cycles with no ack; a later ack is ignored.
    a_req_valid = 1; a_req_we = 1; a_req_addr = 17'h1FFFF; a_req_data = 8'h77;
    step();
    a_req_valid = 0; a_wb_stall = 1;
    cyc_cnt = 0;
    got = 0;
    for (int i = 0; i < 20 && got == 0; i++) begin
      if (a_wb_cyc) cyc_cnt++;
      step();
      if (a_resp_valid) got = 1;
    end
    check("t3_resp_seen", got, 1);
    check("t3_cyc_cycles", cyc_cnt, 8);
    check("t3_err",   a_resp_err, 1);
    check("t3_data",  a_resp_data, 8'h00);
    check("t3_cycdn", a_wb_cyc, 0);
    check("t3_stbdn", a_wb_stb, 0);
    a_wb_stall = 0;
    step();
    a_wb_ack = 1;
    step();
    check("t3_late_rv", a_resp_valid, 0);
    a_wb_ack = 0;
    step();
    check("t3_late_rv2", a_resp_valid, 0);
    check("t3_late_cyc", a_wb_cyc, 0);

    // 4. Back-to-back reads with req_valid held high.
    a_req_valid = 1; a_req_we = 0; a_req_addr = 17'h00000;
    step();
    check("t4_addr0",  a_wb_addr, 17'h00000);
    check("t4_ready0", a_req_ready, 0);
    a_req_addr = 17'h00001; a_wb_ack = 1; a_wb_rdata = 8'h11;
    step();
    check("t4_rv0",   a_resp_valid, 1);
    check("t4_data0", a_resp_data, 8'h11);
    check("t4_rdy0",  a_req_ready, 1);
    a_wb_ack = 0;
    step();
    check("t4_accept1", a_wb_stb, 1);
    check("t4_addr1",   a_wb_addr, 17'h00001);
    check("t4_pulse0",  a_resp_valid, 0);
    a_req_valid = 0; a_wb_ack = 1; a_wb_rdata = 8'h22;
    step();
    check("t4_rv1",   a_resp_valid, 1);
    check("t4_data1", a_resp_data, 8'h22);
    a_wb_ack = 0;
    step();
    check("t4_pulse1", a_resp_valid, 0);

    // 5. Asynchronous reset while waiting for ack.
    a_req_valid = 1; a_req_we = 1; a_req_addr = 17'h00F0F; a_req_data = 8'h5A;
    step();
    a_req_valid = 0;
    step();
    check("t5_waitack_stb", a_wb_stb, 0);
    check("t5_waitack_cyc", a_wb_cyc, 1);
    #2 rst = 1'b1;
    #1;
    check("t5_async_cyc",  a_wb_cyc, 0);
    check("t5_async_stb",  a_wb_stb, 0);
    check("t5_async_addr", a_wb_addr, 0);
    @(negedge clk);
    rst = 1'b0;
    check("t5_rv",    a_resp_valid, 0);
    check("t5_ready", a_req_ready, 1);
    a_wb_ack = 1;
    step();
    check("t5_idle_ack_rv", a_resp_valid, 0);
    a_wb_ack = 0;

    // 6. Zero-wait ack on the strobe-acceptance edge.
    a_req_valid = 1; a_req_we = 0; a_req_addr = 17'h00042;
    step();
    a_req_valid = 0; a_wb_ack = 1; a_wb_rdata = 8'h99;
    step();
    check("t6_rv",    a_resp_valid, 1);
    check("t6_data",  a_resp_data, 8'h99);
    check("t6_err",   a_resp_err, 0);
    check("t6_cyc",   a_wb_cyc, 0);
    check("t6_ready", a_req_ready, 1);
    a_wb_ack = 0;
    step();
    check("t6_pulse", a_resp_valid, 0);

    // 6b. Timeout disabled: a 1000-cycle stall still completes cleanly.
    b_req_valid = 1; b_req_we = 0; b_req_addr = 17'h10000;
    step();
    b_req_valid = 0; b_wb_stall = 1;
    repeat (1000) step();
    check("t6b_cyc", b_wb_cyc, 1);
    check("t6b_stb", b_wb_stb, 1);
    check("t6b_rv",  b_resp_valid, 0);
    b_wb_stall = 0; b_wb_ack = 1; b_wb_rdata = 8'hE7;
    step();
    check("t6b_done_rv",   b_resp_valid, 1);
    check("t6b_done_err",  b_resp_err, 0);
    check("t6b_done_data", b_resp_data, 8'hE7);
    b_wb_ack = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_initiator.md
Name: wb_initiator

Overview:
- Wishbone B4 pipelined initiator. It converts single-beat requests from an on-chip client (SPI bridge, video fetch) into one bus cycle each.
- It drives the wb_* inputs of peripherals such as the SRAM controller, which stalls reads for one cycle and acks one cycle after acceptance.
- It returns read data, or a bus-error flag on timeout, as a one-cycle response pulse.

Parameters:
- DATA_WIDTH, 8, width of the data buses.
- ADDR_WIDTH, 17, width of the address bus.
- TIMEOUT_CYCLES, 255, max cycles wb_cycle_o stays high before abort; 0 disables the timeout.

Ports:
- wb_clock_i  in  1  sole clock.
- wb_reset_i  in  1  asynchronous, active-high reset.
- req_valid_i  in  1  client request present.
- req_ready_o  out  1  initiator can accept a request this cycle.
- req_we_i  in  1  1=write, 0=read.
- req_addr_i  in  ADDR_WIDTH  request address.
- req_data_i  in  DATA_WIDTH  write data.
- resp_valid_o  out  1  one-cycle completion pulse.
- resp_data_o  out  DATA_WIDTH  read data; held until the next response.
- resp_err_o  out  1  qualifies resp_valid_o; 1 = timeout.
- wb_addr_o  out  ADDR_WIDTH  bus address.
- wb_data_o  out  DATA_WIDTH  bus write data.
- wb_data_i  in  DATA_WIDTH  bus read data.
- wb_we_o  out  1  bus write enable.
- wb_cycle_o  out  1  bus cycle.
- wb_strobe_o  out  1  bus strobe.
- wb_stall_i  in  1  peripheral stall.
- wb_ack_i  in  1  peripheral acknowledge.

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE.
  - wb_cycle_o, wb_strobe_o, wb_we_o, resp_valid_o, resp_err_o = 0.
  - wb_addr_o, wb_data_o, resp_data_o = 0.
  - Timeout counter = 0.
  - An in-flight transaction is dropped with no response.
- Outputs: all registered; req_ready_o = (state==IDLE).
- IDLE:
  - On req_valid_i at an edge: latch addr/data/we into wb_*_o, set cyc=stb=1, clear the counter, go to REQUEST.
- REQUEST (cyc=1, stb=1):
  - Edge with !wb_stall_i: stb<=0.
    - If wb_ack_i is also high: complete.
    - Otherwise go to WAIT_ACK.
  - wb_ack_i while wb_stall_i is high is ignored.
- WAIT_ACK (cyc=1, stb=0):
  - Edge with wb_ack_i: complete.
- Complete:
  - cyc<=0, resp_valid_o<=1 for exactly one cycle, resp_err_o<=0.
  - Reads: resp_data_o<=wb_data_i. Writes: resp_data_o unchanged.
  - Go to IDLE, so req_ready_o is high in the same cycle as resp_valid_o.
  - Back-to-back requests are allowed: the next request may be accepted at the edge ending the response cycle.
- Timeout:
  - The counter increments each cycle cyc=1.
  - If TIMEOUT_CYCLES>0, and an edge has count==TIMEOUT_CYCLES-1 and no qualifying ack:
    - cyc<=0, stb<=0.
    - resp_valid_o<=1, resp_err_o<=1, resp_data_o<=0.
    - Go to IDLE.
  - Result: cyc is high for exactly TIMEOUT_CYCLES cycles.
  - Ack on that same edge wins; the transaction completes normally.
- Late ack after a timeout or in IDLE is ignored.
- wb_addr_o, wb_data_o, wb_we_o hold their values from acceptance until the next acceptance.
- resp_valid_o is deasserted on the cycle after its pulse. There is no response back-pressure; the client must sample it.
- Counter width is $clog2(TIMEOUT_CYCLES+1), minimum 1.

Decomposition:
- Package wb_pkg:
  - State enum {IDLE, REQUEST, WAIT_ACK}, 2 bits.
  - Shared localparams for the default widths.
  - Shared with peripherals.
- Sub-module wb_timeout_counter:
  - Inputs: clear, enable.
  - Output: expired.
  - Parameter: TIMEOUT_CYCLES.
  - With TIMEOUT_CYCLES=0, expired is tied low.

Test Plan:
1. Write, with the SRAM controller as peripheral: req we=1 addr=0x1_2345 data=0xA5.
   - Expect: cyc=stb=1 one cycle, ack next cycle, resp_valid=1 err=0, total 3 edges from acceptance.
   - Then a read of 0x1_2345 returns resp_data=0xA5.
2. Read with stall: stall held for 3 cycles, ack 2 cycles after acceptance, data 0x3C.
   - Expect: stb high exactly 4 cycles; addr stable; resp_data=0x3C err=0.
   - Acks asserted during the stall are ignored.
3. Timeout: TIMEOUT_CYCLES=8, peripheral never acks.
   - Expect: cyc high exactly 8 cycles, resp_valid=1 err=1 data=0x00.
   - An ack 2 cycles later produces no response.
4. Back-to-back: req_valid held high with 2 queued reads (0x0000→0x11, 0x0001→0x22).
   - Expect: the second acceptance occurs at the edge ending the first response; responses 0x11 then 0x22, each a single pulse.
5. Reset mid-operation: assert wb_reset_i asynchronously while in WAIT_ACK.
   - Expect: cyc/stb drop without a clock edge; no resp_valid; req_ready=1 after release.
6. Zero-wait ack: peripheral acks on the same edge stall=0 in REQUEST.
   - Expect: completion at that edge, resp_valid next cycle, state IDLE.
   - TIMEOUT_CYCLES=0 variant: an 1000-cycle wait still completes with err=0.
